// File: rtl/seq_gen_if.sv
// Control/status bundle for seq_gen: step/load controls in, index, code and tc out.
// With SEQ_GEN_ONESHOT_EN the bundle also carries oneshot (in) and done (out).
interface seq_gen_if #(
  parameter int WIDTH = 3
);
  logic             en;
  logic             dir;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [1:0]       mode;
  logic [WIDTH-1:0] idx_out;
  logic [WIDTH-1:0] seq_out;
  logic             tc;
`ifdef SEQ_GEN_ONESHOT_EN
  logic             oneshot;
  logic             done;

  modport master (
    output en, dir, load, load_val, mode, oneshot,
    input  idx_out, seq_out, tc, done
  );
  modport slave (
    input  en, dir, load, load_val, mode, oneshot,
    output idx_out, seq_out, tc, done
  );
`else
  modport master (
    output en, dir, load, load_val, mode,
    input  idx_out, seq_out, tc
  );
  modport slave (
    input  en, dir, load, load_val, mode,
    output idx_out, seq_out, tc
  );
`endif
endinterface

// File: rtl/seq_gen.sv
// Up/down index sequencer over LENGTH states with binary/Gray/scrambled output coding.
// Optional SEQ_GEN_ONESHOT_EN: stop at the terminal state instead of wrapping, flag done.
module seq_gen #(
  parameter int               WIDTH  = 3,
  parameter int               LENGTH = 8,
  parameter logic [WIDTH-1:0] KEY    = WIDTH'(5)
) (
  input  logic    clk,
  input  logic    rst,
  seq_gen_if.slave bus
);
  localparam logic [WIDTH-1:0] LAST = WIDTH'(LENGTH - 1);

  logic [WIDTH-1:0] idx;
  logic [1:0]       mode_q;
  logic [WIDTH-1:0] ld_idx;
  logic [WIDTH-1:0] nxt_idx;
  logic             at_end;
  logic             step;

  function automatic logic [WIDTH-1:0] encode(input logic [WIDTH-1:0] i,
                                              input logic [1:0]       m);
    logic [WIDTH-1:0] c;
    c = m[0] ? (i ^ (i >> 1)) : i;
    return m[1] ? (c ^ KEY) : c;
  endfunction

  // Out-of-range loads clamp so idx never leaves 0..LENGTH-1.
  assign ld_idx = (bus.load_val > LAST) ? LAST : bus.load_val;
  assign at_end = bus.dir ? (idx == LAST) : (idx == '0);

  always_comb begin
    nxt_idx = idx;
    if (bus.dir) nxt_idx = at_end ? '0   : idx + WIDTH'(1);
    else         nxt_idx = at_end ? LAST : idx - WIDTH'(1);
  end

`ifdef SEQ_GEN_ONESHOT_EN
  logic done_q;

  // Once done, en is dead until a load re-arms the sequencer.
  assign step = bus.en & ~done_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx    <= '0;
      mode_q <= 2'b00;
      done_q <= 1'b0;
    end else begin
      mode_q <= bus.mode;
      if (bus.load) begin
        idx    <= ld_idx;
        done_q <= 1'b0;
      end else if (step) begin
        if (bus.oneshot && at_end) done_q <= 1'b1;
        else                       idx    <= nxt_idx;
      end
    end
  end

  assign bus.done = done_q;
`else
  assign step = bus.en;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx    <= '0;
      mode_q <= 2'b00;
    end else begin
      mode_q <= bus.mode;
      if (bus.load)  idx <= ld_idx;
      else if (step) idx <= nxt_idx;
    end
  end
`endif

  assign bus.idx_out = idx;
  assign bus.seq_out = encode(idx, mode_q);
  assign bus.tc      = step & ~bus.load & at_end;
endmodule

// File: tb/tb_seq_gen.sv
// Directed bench for seq_gen: one LENGTH=8 and one LENGTH=5 instance on a shared clock/reset.
module tb_seq_gen;
  logic clk;
  logic rst;
  int   n_chk;
  int   n_err;

  int gtab[9] = '{0, 1, 3, 2, 6, 7, 5, 4, 0};
  int stab[4] = '{5, 4, 7, 6};
  int btab[6] = '{0, 4, 3, 2, 1, 0};

  seq_gen_if #(.WIDTH(3)) a ();
  seq_gen_if #(.WIDTH(3)) b ();

  seq_gen #(.WIDTH(3), .LENGTH(8), .KEY(3'b101)) u_a (.clk(clk), .rst(rst), .bus(a.slave));
  seq_gen #(.WIDTH(3), .LENGTH(5), .KEY(3'b101)) u_b (.clk(clk), .rst(rst), .bus(b.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rst = 1'b0;
    a.en = 0; a.dir = 0; a.load = 0; a.load_val = '0; a.mode = 2'b01;
    b.en = 0; b.dir = 0; b.load = 0; b.load_val = '0; b.mode = 2'b00;
`ifdef SEQ_GEN_ONESHOT_EN
    a.oneshot = 0; b.oneshot = 0;
`endif
    repeat (2) @(negedge clk);
    #1;
    chk("rst_idx", int'(a.idx_out), 0);
    chk("rst_seq", int'(a.seq_out), 0);
    chk("rst_b_idx", int'(b.idx_out), 0);
    @(negedge clk);
    rst = 1'b1;

    // Gray count up through a full wrap
    @(negedge clk);
    a.en = 1; a.dir = 1; a.mode = 2'b01;
    #1;
    chk("gray_idx0", int'(a.idx_out), 0);
    chk("gray_seq0", int'(a.seq_out), 0);
    chk("gray_tc0", int'(a.tc), 0);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk); #1;
      chk("gray_idx", int'(a.idx_out), k % 8);
      chk("gray_seq", int'(a.seq_out), gtab[k]);
      chk("gray_tc", int'(a.tc), int'(k == 7));
    end

    // Scrambled binary, then mode switches with idx frozen
    a.en = 0; a.mode = 2'b10;
    @(negedge clk); #1;
    chk("scr_idx0", int'(a.idx_out), 0);
    chk("scr_seq0", int'(a.seq_out), 5);
    a.en = 1;
    for (int j = 1; j <= 3; j++) begin
      @(negedge clk); #1;
      chk("scr_idx", int'(a.idx_out), j);
      chk("scr_seq", int'(a.seq_out), stab[j]);
    end
    a.en = 0; a.mode = 2'b00;
    #1;
    chk("mode_lag_seq", int'(a.seq_out), 6);
    @(negedge clk); #1;
    chk("mode00_idx", int'(a.idx_out), 3);
    chk("mode00_seq", int'(a.seq_out), 3);
    a.mode = 2'b11;
    @(negedge clk); #1;
    chk("mode11_seq", int'(a.seq_out), 7);
    chk("mode11_idx", int'(a.idx_out), 3);

    // Load beats en; tc masked by load even at the terminal state
    a.mode = 2'b00; a.load = 1; a.load_val = 3'd7;
    @(negedge clk); #1;
    chk("ld7_idx", int'(a.idx_out), 7);
    a.en = 1; a.dir = 1; a.load_val = 3'd2;
    #1;
    chk("ld_tc", int'(a.tc), 0);
    @(negedge clk); #1;
    chk("ld2_idx", int'(a.idx_out), 2);
    a.load = 0; a.en = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      chk("hold_idx", int'(a.idx_out), 2);
      chk("hold_tc", int'(a.tc), 0);
    end

    // Direction flip takes effect on the very next step
    a.en = 1; a.dir = 0;
    @(negedge clk); #1;
    chk("dir_dn_idx", int'(a.idx_out), 1);
    a.dir = 1;
    @(negedge clk); #1;
    chk("dir_up_idx", int'(a.idx_out), 2);

    // Asynchronous reset mid-cycle, then resume from 0
    a.en = 0; a.load = 1; a.load_val = 3'd5;
    @(negedge clk); #1;
    chk("pre_rst_idx", int'(a.idx_out), 5);
    chk("pre_rst_seq", int'(a.seq_out), 5);
    a.load = 0; a.en = 1;
    #1 rst = 1'b0;
    #1;
    chk("async_rst_idx", int'(a.idx_out), 0);
    chk("async_rst_seq", int'(a.seq_out), 0);
    #1 rst = 1'b1;
    @(negedge clk); #1;
    chk("resume_idx", int'(a.idx_out), 1);
    chk("resume_seq", int'(a.seq_out), 1);
    a.en = 0;

    // LENGTH=5: count down with wrap, clamp, up wrap
    b.en = 1; b.dir = 0;
    #1;
    chk("b_tc0", int'(b.tc), 1);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk); #1;
      chk("b_dn_idx", int'(b.idx_out), btab[k]);
      chk("b_dn_tc", int'(b.tc), int'(btab[k] == 0));
    end
    b.en = 0; b.load = 1; b.load_val = 3'd7;
    @(negedge clk); #1;
    chk("b_clamp_idx", int'(b.idx_out), 4);
    chk("b_clamp_seq", int'(b.seq_out), 4);
    b.load = 0; b.en = 1; b.dir = 1;
    #1;
    chk("b_up_tc", int'(b.tc), 1);
    @(negedge clk); #1;
    chk("b_up_wrap", int'(b.idx_out), 0);
    b.en = 0;

`ifdef SEQ_GEN_ONESHOT_EN
    // One-shot: stop at 7, ignore en, load re-arms
    a.load = 1; a.load_val = 3'd0; a.oneshot = 1;
    @(negedge clk); #1;
    chk("os_ld_idx", int'(a.idx_out), 0);
    chk("os_ld_done", int'(a.done), 0);
    a.load = 0; a.en = 1; a.dir = 1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk); #1;
      chk("os_idx", int'(a.idx_out), k);
      chk("os_tc", int'(a.tc), int'(k == 7));
      chk("os_done", int'(a.done), 0);
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); #1;
      chk("os_stop_idx", int'(a.idx_out), 7);
      chk("os_stop_done", int'(a.done), 1);
      chk("os_stop_tc", int'(a.tc), 0);
    end
    a.load = 1; a.load_val = 3'd0;
    @(negedge clk); #1;
    chk("os_rearm_done", int'(a.done), 0);
    chk("os_rearm_idx", int'(a.idx_out), 0);
    a.load = 0;
    @(negedge clk); #1;
    chk("os_restart_idx", int'(a.idx_out), 1);
    a.en = 0; a.oneshot = 0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
